// File: rtl/bit_unstuffer.sv
// ============================================================================
// bit_unstuffer : receive-side USB bit unstuffer (PID pass-through, stuff-0 strip)
// Revision 1.0
// ============================================================================
`default_nettype none

module bit_unstuffer #(
  parameter int PID_BITS = 8,
  parameter int MAX_ONES = 6
) (
  input  logic clock,
  input  logic reset_n,
  input  logic in_active,
  input  logic in_valid,
  input  logic in_bit,
  output logic out_valid,
  output logic out_bit,
  output logic out_pid,
  output logic stripped,
  output logic stuff_err,
  output logic busy
);

  localparam int CW = $clog2(PID_BITS + 1);
  localparam int OW = $clog2(MAX_ONES + 1);

  localparam logic [CW-1:0] c_PID_LAST = CW'(PID_BITS - 1);
  localparam logic [OW-1:0] c_ONES_MAX = OW'(MAX_ONES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PID   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STRIP = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic          valid_q, valid_d;
  logic          bit_q, bit_d;
  logic          pid_q, pid_d;
  logic          strip_q, strip_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic [OW-1:0] w_ones_inc;

  // ones_cnt never exceeds MAX_ONES-1 while in DATA, so the increment cannot wrap
  assign w_ones_inc = ones_cnt_q + OW'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    ones_cnt_d = ones_cnt_q;
    valid_d    = 1'b0;
    bit_d      = 1'b0;
    pid_d      = 1'b0;
    strip_d    = 1'b0;
    err_d      = 1'b0;

    if ((state_q != S_IDLE) && !in_active) begin
      // End of packet wins over any coincident in_valid
      state_d    = S_IDLE;
      bit_cnt_d  = '0;
      ones_cnt_d = '0;
      err_d      = (state_q == S_STRIP);
    end else if (in_active && in_valid) begin
      case (state_q)
        S_IDLE: begin
          valid_d    = 1'b1;
          bit_d      = in_bit;
          pid_d      = 1'b1;
          bit_cnt_d  = CW'(1);
          ones_cnt_d = '0;
          state_d    = S_PID;
        end
        S_PID: begin
          valid_d   = 1'b1;
          bit_d     = in_bit;
          pid_d     = 1'b1;
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == c_PID_LAST) begin
            ones_cnt_d = '0;
            state_d    = S_DATA;
          end
        end
        S_DATA: begin
          valid_d = 1'b1;
          bit_d   = in_bit;
          if (in_bit) begin
            if (w_ones_inc == c_ONES_MAX) begin
              ones_cnt_d = '0;
              state_d    = S_STRIP;
            end else begin
              ones_cnt_d = w_ones_inc;
            end
          end else begin
            ones_cnt_d = '0;
          end
        end
        S_STRIP: begin
          if (in_bit) begin
            err_d   = 1'b1;
            state_d = S_DROP;
          end else begin
            strip_d = 1'b1;
            state_d = S_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      ones_cnt_q <= '0;
      valid_q    <= 1'b0;
      bit_q      <= 1'b0;
      pid_q      <= 1'b0;
      strip_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_cnt_q <= ones_cnt_d;
      valid_q    <= valid_d;
      bit_q      <= bit_d;
      pid_q      <= pid_d;
      strip_q    <= strip_d;
      err_q      <= err_d;
      busy_q     <= (state_d != S_IDLE);
    end
  end

  assign out_valid = valid_q;
  assign out_bit   = bit_q;
  assign out_pid   = pid_q;
  assign stripped  = strip_q;
  assign stuff_err = err_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire
